// File: rtl/riscv_pkg.sv
// Shared types for the load/store unit: funct3 memory op encodings and FSM states.
package riscv_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: request checks, byte enables, store replication
// and little-endian load extraction with sign/zero extension.
module lsu_align (
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        illegal,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);
  import riscv_pkg::*;

  logic [31:0] lane;

  always_comb begin
    illegal     = 1'b0;
    misaligned  = 1'b0;
    be          = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_op)
      LSU_B, LSU_BU: begin
        be          = 4'b0001 << req_off;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      LSU_H, LSU_HU: begin
        misaligned  = req_off[0];
        be          = 4'b0011 << req_off;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      LSU_W: begin
        misaligned = |req_off;
        be         = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
    // unsigned variants exist only for loads
    if (req_we && req_op[2]) illegal = 1'b1;
  end

  always_comb begin
    lane    = rdata >> {ld_off, 3'b000};
    ld_data = lane;
    case (ld_op)
      LSU_B:   ld_data = {{24{lane[7]}}, lane[7:0]};
      LSU_BU:  ld_data = {24'h000000, lane[7:0]};
      LSU_H:   ld_data = {{16{lane[15]}}, lane[15:0]};
      LSU_HU:  ld_data = {16'h0000, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one load/store, runs it over the req/ack port with a
// bus timeout, and returns a single registered response.
//   state  | meaning
//   IDLE   | ready for a new op
//   ACCESS | mem_req held, waiting for mem_ack or timeout
//   RESP   | rsp_valid strobe for one cycle
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_misaligned,
  output logic        rsp_err
);
  import riscv_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_mis_q, rsp_mis_d;
  logic              rsp_err_q, rsp_err_d;

  logic        chk_illegal, chk_misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  lsu_align u_align (
    .req_we      (req_we),
    .req_op      (req_op),
    .req_off     (req_addr[1:0]),
    .req_wdata   (req_wdata),
    .illegal     (chk_illegal),
    .misaligned  (chk_misaligned),
    .be          (st_be),
    .wdata_lanes (st_wdata),
    .ld_op       (op_q),
    .ld_off      (off_q),
    .rdata       (mem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_err_d   = rsp_err_q;
    cnt_inc     = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          off_d = req_addr[1:0];
          if (chk_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'h0;
            state_d     = RESP;
          end else if (chk_misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
            rsp_data_d  = 32'h0;
            state_d     = RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
            cnt_d       = '0;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_inc;
        // ack takes priority over a timeout landing in the same cycle
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_we_q ? 32'h0 : ld_data;
          state_d     = RESP;
        end else if (cnt_inc == CNT_LIMIT) begin
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'h0;
          state_d     = RESP;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b0;
        rsp_mis_d   = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = 32'h0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_mis_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_be         = mem_be_q;
  assign mem_wdata      = mem_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_misaligned = rsp_mis_q;
  assign rsp_err        = rsp_err_q;

endmodule
